// File: rtl/pc_return_stack_if.sv
// Call/return bus between the PC controller and the return-address stack.
interface pc_return_stack_if #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic             flush;
  logic             err_clr;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             stack_overflow;
  logic             stack_underflow;

  modport master (
    output push, pop, flush, err_clr, push_data,
    input  top, count, empty, full, stack_overflow, stack_underflow
  );

  modport slave (
    input  push, pop, flush, err_clr, push_data,
    output top, count, empty, full, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/pc_return_stack.sv
// Parametrised return-address stack with replace, flush, occupancy count
// and sticky overflow/underflow flags.
module pc_return_stack #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  pc_return_stack_if.slave   bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             ovf_q;
  logic             unf_q;
  logic             ovf_set;
  logic             unf_set;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  // Wraps when empty; the top mux hides that entry.
  assign top_idx  = AW'(count_q - CW'(1));

  // Operation decode in priority order: flush, replace, push, pop.
  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = top_idx;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.flush) begin
      count_d = '0;
    end else if (bus.push && bus.pop) begin
      wr_en = 1'b1;
      if (is_empty) begin
        unf_set = 1'b1;
        wr_idx  = '0;
        count_d = CW'(1);
      end
    end else if (bus.push) begin
      if (is_full) begin
        ovf_set = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_idx  = AW'(count_q);
        count_d = count_q + CW'(1);
      end
    end else if (bus.pop) begin
      if (is_empty) begin
        unf_set = 1'b1;
      end else begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Occupancy and sticky flags; a new error wins over err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_set | (ovf_q & ~bus.err_clr);
      unf_q   <= unf_set | (unf_q & ~bus.err_clr);
    end
  end

  // Storage needs no reset: entries at or above count are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= bus.push_data;
    end
  end

  assign bus.top             = is_empty ? '0 : mem[top_idx];
  assign bus.count           = count_q;
  assign bus.empty           = is_empty;
  assign bus.full            = is_full;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_pc_return_stack.sv
// Bench for pc_return_stack: directed vector table on the default build,
// hand sequences for reset/sweep corners, random traffic against a queue model.
module tb_pc_return_stack;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_return_stack_if #(.WIDTH(12), .DEPTH(8)) if0 ();
  pc_return_stack_if #(.WIDTH(19), .DEPTH(5)) if1 ();
  pc_return_stack_if #(.WIDTH(8),  .DEPTH(2)) if2 ();

  pc_return_stack #(.WIDTH(12), .DEPTH(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  pc_return_stack #(.WIDTH(19), .DEPTH(5)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  pc_return_stack #(.WIDTH(8),  .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  int checks = 0;
  int failures = 0;

  // Reference model: one queue per instance, back of queue is the top.
  int unsigned    mdep [3] = '{8, 5, 2};
  int unsigned    mwid [3] = '{12, 19, 8};
  logic [31:0]    mq   [3][$];
  bit             movf [3];
  bit             munf [3];

  bit          cur_f, cur_pu, cur_po, cur_ec;
  logic [31:0] cur_d;

  typedef struct {
    bit f; bit pu; bit po; bit ec; logic [31:0] d;
    logic [31:0] c; logic [31:0] t; bit e; bit fu; bit o; bit u;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic read_dut(input int k, output logic [31:0] t, output logic [31:0] c,
                          output logic e, output logic fu, output logic o, output logic u);
    case (k)
      0: begin t = 32'(if0.top); c = 32'(if0.count); e = if0.empty; fu = if0.full;
               o = if0.stack_overflow; u = if0.stack_underflow; end
      1: begin t = 32'(if1.top); c = 32'(if1.count); e = if1.empty; fu = if1.full;
               o = if1.stack_overflow; u = if1.stack_underflow; end
      default: begin t = 32'(if2.top); c = 32'(if2.count); e = if2.empty; fu = if2.full;
               o = if2.stack_overflow; u = if2.stack_underflow; end
    endcase
  endtask

  task automatic drive(input bit f, input bit pu, input bit po, input bit ec, input logic [31:0] d);
    cur_f = f; cur_pu = pu; cur_po = po; cur_ec = ec; cur_d = d;
    if0.flush = f; if0.push = pu; if0.pop = po; if0.err_clr = ec; if0.push_data = 12'(d);
    if1.flush = f; if1.push = pu; if1.pop = po; if1.err_clr = ec; if1.push_data = 19'(d);
    if2.flush = f; if2.push = pu; if2.pop = po; if2.err_clr = ec; if2.push_data = 8'(d);
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      bit os;
      bit us;
      logic [31:0] dm;
      os = 1'b0;
      us = 1'b0;
      dm = cur_d & 32'((64'(1) << mwid[k]) - 64'(1));
      if (cur_f) begin
        mq[k].delete();
      end else if (cur_pu && cur_po) begin
        if (mq[k].size() > 0) mq[k][mq[k].size() - 1] = dm;
        else begin us = 1'b1; mq[k].push_back(dm); end
      end else if (cur_pu) begin
        if (mq[k].size() < int'(mdep[k])) mq[k].push_back(dm);
        else os = 1'b1;
      end else if (cur_po) begin
        if (mq[k].size() > 0) void'(mq[k].pop_back());
        else us = 1'b1;
      end
      movf[k] = os | (movf[k] & !cur_ec);
      munf[k] = us | (munf[k] & !cur_ec);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      movf[k] = 1'b0;
      munf[k] = 1'b0;
    end
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] t, c;
    logic e, fu, o, u;
    for (int k = 0; k < 3; k++) begin
      int sz;
      sz = mq[k].size();
      read_dut(k, t, c, e, fu, o, u);
      chk($sformatf("%s dut%0d count", tag, k), c, 32'(sz));
      chk($sformatf("%s dut%0d top", tag, k), t, (sz > 0) ? mq[k][sz - 1] : 32'd0);
      chk($sformatf("%s dut%0d empty", tag, k), 32'(e), 32'(sz == 0));
      chk($sformatf("%s dut%0d full", tag, k), 32'(fu), 32'(sz == int'(mdep[k])));
      chk($sformatf("%s dut%0d ovf", tag, k), 32'(o), 32'(movf[k]));
      chk($sformatf("%s dut%0d unf", tag, k), 32'(u), 32'(munf[k]));
    end
  endtask

  // One clock of activity; results are sampled 1 time unit after the edge.
  task automatic step(input bit f, input bit pu, input bit po, input bit ec,
                      input logic [31:0] d, input string tag);
    drive(f, pu, po, ec, d);
    @(posedge clk);
    model_update();
    #1;
    chk_model(tag);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic add(input bit f, input bit pu, input bit po, input bit ec, input logic [31:0] d,
                     input logic [31:0] c, input logic [31:0] t,
                     input bit e, input bit fu, input bit o, input bit u);
    vec_t v;
    v = '{f, pu, po, ec, d, c, t, e, fu, o, u};
    tv.push_back(v);
  endtask

  initial begin
    logic [31:0] t, c;
    logic e, fu, o, u;

    // Directed vectors for the WIDTH=12, DEPTH=8 build.
    add(0,1,0,0, 32'h010, 1, 32'h010, 0,0,0,0);
    add(0,1,0,0, 32'h020, 2, 32'h020, 0,0,0,0);
    add(0,1,0,0, 32'h030, 3, 32'h030, 0,0,0,0);
    add(0,0,1,0, 0,       2, 32'h020, 0,0,0,0);
    add(0,0,1,0, 0,       1, 32'h010, 0,0,0,0);
    add(0,0,1,0, 0,       0, 0,       1,0,0,0);
    add(0,0,1,0, 0,       0, 0,       1,0,0,1);
    add(0,0,0,1, 0,       0, 0,       1,0,0,0);
    add(0,1,1,0, 32'h055, 1, 32'h055, 0,0,0,1);
    add(0,0,0,1, 0,       1, 32'h055, 0,0,0,0);
    add(1,0,0,0, 0,       0, 0,       1,0,0,0);
    for (int i = 1; i <= 8; i++) add(0,1,0,0, 32'(i), 32'(i), 32'(i), 0, i == 8, 0, 0);
    add(0,1,0,0, 32'd9,   8, 32'd8,   0,1,1,0);
    add(0,0,0,1, 0,       8, 32'd8,   0,1,0,0);
    add(0,1,1,0, 32'h077, 8, 32'h077, 0,1,0,0);
    add(0,1,0,1, 32'd9,   8, 32'h077, 0,1,1,0);
    add(0,0,1,0, 0,       7, 32'd7,   0,0,1,0);
    add(0,0,1,0, 0,       6, 32'd6,   0,0,1,0);
    add(0,0,1,0, 0,       5, 32'd5,   0,0,1,0);
    add(1,1,0,0, 32'h0AA, 0, 0,       1,0,1,0);
    add(0,1,0,0, 32'h0BB, 1, 32'h0BB, 0,0,1,0);
    add(0,1,0,0, 32'hFFF, 2, 32'hFFF, 0,0,1,0);

    do_reset();
    #1;
    chk_model("reset");

    foreach (tv[i]) begin
      step(tv[i].f, tv[i].pu, tv[i].po, tv[i].ec, tv[i].d, $sformatf("vec%0d", i));
      read_dut(0, t, c, e, fu, o, u);
      chk($sformatf("vec%0d count", i), c, tv[i].c);
      chk($sformatf("vec%0d top", i), t, tv[i].t);
      chk($sformatf("vec%0d empty", i), 32'(e), 32'(tv[i].e));
      chk($sformatf("vec%0d full", i), 32'(fu), 32'(tv[i].fu));
      chk($sformatf("vec%0d ovf", i), 32'(o), 32'(tv[i].o));
      chk($sformatf("vec%0d unf", i), 32'(u), 32'(tv[i].u));
    end

    // Depth sweep: six pushes saturate the 5- and 2-deep builds.
    do_reset();
    for (int i = 1; i <= 6; i++) step(0, 1, 0, 0, 32'(i), $sformatf("sweep%0d", i));
    chk("sweep d5 count", 32'(if1.count), 32'd5);
    chk("sweep d5 full", 32'(if1.full), 32'd1);
    chk("sweep d5 ovf", 32'(if1.stack_overflow), 32'd1);
    chk("sweep d5 top", 32'(if1.top), 32'd5);
    chk("sweep d2 count", 32'(if2.count), 32'd2);
    chk("sweep d2 top", 32'(if2.top), 32'd2);
    chk("sweep d8 ovf", 32'(if0.stack_overflow), 32'd0);

    // Async reset between edges with 4 entries and overflow pending.
    do_reset();
    for (int i = 1; i <= 9; i++) step(0, 1, 0, 0, 32'(i + 16), "pre_rst push");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, "pre_rst pop");
    chk("pre_rst d8 count", 32'(if0.count), 32'd4);
    chk("pre_rst d8 ovf", 32'(if0.stack_overflow), 32'd1);
    drive(0, 1, 0, 0, 32'h123);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk_model("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step(0, 1, 0, 0, 32'h0C3, "post_rst");

    // Random traffic against the model across all three builds.
    for (int n = 0; n < 600; n++) begin
      int r;
      bit f, pu, po, ec;
      r  = int'($urandom_range(0, 99));
      f  = (r < 3);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 40);
      ec = ($urandom_range(0, 99) < 8);
      step(f, pu, po, ec, $urandom, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
